// File: rtl/bias_mem_stream.sv
// bias_mem_stream: bias word store for the fully-connected stages.
// The host side gets a random-access write port and a registered read port.
// The datapath side gets a sequencer that streams a programmable window of
// entries over valid/ready, with optional looping and an abort input.
// Storage is a resettable flop array, so a reset leaves every word at zero.
module bias_mem_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  loop,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] bias_data,
    output logic                  bias_valid,
    input  logic                  bias_ready,
    output logic                  pass_done,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // storage and host read port
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;

    // stream sequencer
    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [ADDR_WIDTH:0]   remaining_d;
    logic [ADDR_WIDTH-1:0] shadow_addr_q;
    logic [ADDR_WIDTH-1:0] shadow_addr_d;
    logic [ADDR_WIDTH:0]   shadow_count_q;
    logic [ADDR_WIDTH:0]   shadow_count_d;
    logic                  shadow_loop_q;
    logic                  shadow_loop_d;
    logic [DATA_WIDTH-1:0] bias_data_q;
    logic [DATA_WIDTH-1:0] bias_data_d;
    logic                  bias_valid_q;
    logic                  bias_valid_d;
    logic                  pass_done_q;
    logic                  pass_done_d;
    logic                  load_ok;

    // Next memory image: only the host port writes. Both readers look at
    // mem_q, so a same-edge read of a word being written sees the old word.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Host read: one-cycle latency, data holds between reads.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Stream FSM next-state: loads a new word whenever the output slot is
    // empty or being accepted. Stop overrides everything else in RUN.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        remaining_d    = remaining_q;
        shadow_addr_d  = shadow_addr_q;
        shadow_count_d = shadow_count_q;
        shadow_loop_d  = shadow_loop_q;
        bias_data_d    = bias_data_q;
        bias_valid_d   = bias_valid_q;
        pass_done_d    = 1'b0;
        load_ok        = !bias_valid_q || bias_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = RUN;
                    ptr_d          = start_addr;
                    remaining_d    = count;
                    shadow_addr_d  = start_addr;
                    shadow_count_d = count;
                    shadow_loop_d  = loop;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d      = IDLE;
                    bias_valid_d = 1'b0;
                end else if (load_ok) begin
                    if (remaining_q != '0) begin
                        bias_data_d  = mem_q[ptr_q];
                        bias_valid_d = 1'b1;
                        ptr_d        = ptr_q + 1'b1;
                        remaining_d  = remaining_q - 1'b1;
                    end else if (!shadow_loop_q) begin
                        bias_valid_d = 1'b0;
                        pass_done_d  = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        // Pass boundary while looping: the first word of the
                        // next pass goes out on this same edge, so a held
                        // ready sees no bubble between passes.
                        pass_done_d = 1'b1;
                        if (shadow_count_q != '0) begin
                            bias_data_d  = mem_q[shadow_addr_q];
                            bias_valid_d = 1'b1;
                            ptr_d        = shadow_addr_q + 1'b1;
                            remaining_d  = shadow_count_q - 1'b1;
                        end else begin
                            bias_valid_d = 1'b0;
                            ptr_d        = shadow_addr_q;
                            remaining_d  = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory and host read registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Stream sequencer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            remaining_q    <= '0;
            shadow_addr_q  <= '0;
            shadow_count_q <= '0;
            shadow_loop_q  <= 1'b0;
            bias_data_q    <= '0;
            bias_valid_q   <= 1'b0;
            pass_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            remaining_q    <= remaining_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_count_q <= shadow_count_d;
            shadow_loop_q  <= shadow_loop_d;
            bias_data_q    <= bias_data_d;
            bias_valid_q   <= bias_valid_d;
            pass_done_q    <= pass_done_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign bias_data  = bias_data_q;
    assign bias_valid = bias_valid_q;
    assign pass_done  = pass_done_q;
    assign busy       = (state_q == RUN);

endmodule
